// File: rtl/gt_sync_rx_if.sv
// Word-serial beat stream carrying the broadcast global time into a tile.
// The sender drives valid/sof/data; the receiver applies backpressure with ready.
interface gt_sync_rx_if #(
  parameter int BEAT_W = 16
);
  logic              rx_valid;
  logic              rx_sof;
  logic [BEAT_W-1:0] rx_data;
  logic              rx_ready;

  modport master (output rx_valid, output rx_sof, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_sof, input rx_data, output rx_ready);
endinterface

// File: rtl/gt_sync_rx.sv
// Global-time receiver: reassembles the MSB-first time frame and keeps the tile-local
// macrotick counter aligned to it, with latency compensation and a bounded correction window.
module gt_sync_rx #(
  parameter int BEAT_W       = 16,
  parameter int LAT_COMP     = 2,
  parameter int MAX_DEV      = 4,
  parameter int REJECT_LIMIT = 2,
  parameter int TIMEOUT_MT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtclk,
  gt_sync_rx_if.slave rx,
  output logic [63:0] TimeCnt,
  output logic        synced,
  output logic        sync_err,
  output logic        frame_err,
  output logic [15:0] deviation
);

  localparam int NBEATS = 64 / BEAT_W;
  localparam int BCNT_W = $clog2(NBEATS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_MT + 1);
  localparam int REJ_W  = $clog2(REJECT_LIMIT + 2);

  localparam logic [BCNT_W-1:0] LAST_BEAT   = BCNT_W'(NBEATS - 1);
  localparam logic [BCNT_W-1:0] ONE_BEAT    = BCNT_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_MT - 1);
  localparam logic [REJ_W-1:0]  REJ_LIM     = REJ_W'(REJECT_LIMIT);
  localparam logic signed [63:0] MAX_DEV_S  = 64'(MAX_DEV);
  localparam logic [63:0]       LAT_COMP_V  = 64'(LAT_COMP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t              state_r, state_n;
  logic [63:0]         shift_r, shift_n;
  logic [BCNT_W-1:0]   beat_cnt_r, beat_cnt_n;
  logic [REJ_W-1:0]    rej_cnt_r, rej_cnt_n;
  logic [TO_W-1:0]     to_cnt_r, to_cnt_n;
  logic [63:0]         time_r, time_n;
  logic                synced_r, synced_n;
  logic                sync_err_r, sync_err_n;
  logic                frame_err_r, frame_err_n;
  logic [15:0]         dev_r, dev_n;
  logic                rx_ready_r, rx_ready_n;

  logic                beat_s;
  logic [63:0]         shift_next_s;
  logic [63:0]         target_s;
  logic [63:0]         dev_s;
  logic                within_s;
  logic                accept_s;

  // Clamp a 64-bit two's-complement difference to the symmetric 16-bit range +/-32767.
  function automatic logic [15:0] sat16(input logic [63:0] v);
    logic signed [63:0] sv;
    sv = $signed(v);
    if (sv > 64'sd32767) begin
      sat16 = 16'h7FFF;
    end else if (sv < -64'sd32767) begin
      sat16 = 16'h8001;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  assign beat_s       = rx.rx_valid && rx_ready_r;
  assign shift_next_s = (shift_r << BEAT_W) | 64'(rx.rx_data);
  assign target_s     = shift_r + LAT_COMP_V;
  assign dev_s        = target_s - time_r;
  assign within_s     = ($signed(dev_s) <= MAX_DEV_S) && ($signed(dev_s) >= -MAX_DEV_S);
  assign accept_s     = !synced_r || within_s || (rej_cnt_r >= REJ_LIM);

  // Next-state, datapath and pulse generation for framing, checking and timeout.
  always_comb begin
    state_n     = state_r;
    shift_n     = shift_r;
    beat_cnt_n  = beat_cnt_r;
    rej_cnt_n   = rej_cnt_r;
    to_cnt_n    = to_cnt_r;
    time_n      = time_r + 64'(mtclk);
    synced_n    = synced_r;
    sync_err_n  = 1'b0;
    frame_err_n = 1'b0;
    dev_n       = dev_r;

    if (synced_r && mtclk) begin
      if (to_cnt_r == TO_LAST) begin
        synced_n = 1'b0;
        to_cnt_n = TO_W'(0);
      end else begin
        to_cnt_n = to_cnt_r + TO_W'(1);
      end
    end else begin
      to_cnt_n = to_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (beat_s && rx.rx_sof) begin
          shift_n    = shift_next_s;
          beat_cnt_n = ONE_BEAT;
          state_n    = (NBEATS == 1) ? CHECK : RECV;
        end else if (beat_s) begin
          frame_err_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RECV: begin
        if (beat_s && rx.rx_sof) begin
          // A new sof restarts the frame; the partial data shifts out unused.
          frame_err_n = 1'b1;
          shift_n     = shift_next_s;
          beat_cnt_n  = ONE_BEAT;
          state_n     = (NBEATS == 1) ? CHECK : RECV;
        end else if (beat_s && (beat_cnt_r == LAST_BEAT)) begin
          shift_n    = shift_next_s;
          beat_cnt_n = BCNT_W'(0);
          state_n    = CHECK;
        end else if (beat_s) begin
          shift_n    = shift_next_s;
          beat_cnt_n = beat_cnt_r + ONE_BEAT;
        end else begin
          state_n = RECV;
        end
      end
      CHECK: begin
        dev_n      = sat16(dev_s);
        beat_cnt_n = BCNT_W'(0);
        state_n    = IDLE;
        if (accept_s) begin
          time_n    = target_s + 64'(mtclk);
          synced_n  = 1'b1;
          rej_cnt_n = REJ_W'(0);
          to_cnt_n  = TO_W'(0);
        end else begin
          sync_err_n = 1'b1;
          if (rej_cnt_r != {REJ_W{1'b1}}) begin
            rej_cnt_n = rej_cnt_r + REJ_W'(1);
          end else begin
            rej_cnt_n = rej_cnt_r;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    rx_ready_n = (state_n != CHECK);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r     <= 64'd0;
      beat_cnt_r  <= BCNT_W'(0);
      rej_cnt_r   <= REJ_W'(0);
      to_cnt_r    <= TO_W'(0);
      time_r      <= 64'd0;
      synced_r    <= 1'b0;
      sync_err_r  <= 1'b0;
      frame_err_r <= 1'b0;
      dev_r       <= 16'd0;
      rx_ready_r  <= 1'b1;
    end else begin
      shift_r     <= shift_n;
      beat_cnt_r  <= beat_cnt_n;
      rej_cnt_r   <= rej_cnt_n;
      to_cnt_r    <= to_cnt_n;
      time_r      <= time_n;
      synced_r    <= synced_n;
      sync_err_r  <= sync_err_n;
      frame_err_r <= frame_err_n;
      dev_r       <= dev_n;
      rx_ready_r  <= rx_ready_n;
    end
  end

  assign TimeCnt     = time_r;
  assign synced      = synced_r;
  assign sync_err    = sync_err_r;
  assign frame_err   = frame_err_r;
  assign deviation   = dev_r;
  assign rx.rx_ready = rx_ready_r;

endmodule

// File: tb/tb_gt_sync_rx.sv
// Directed bench for gt_sync_rx: frames are driven from one initial block, expected
// check results go into a scoreboard queue that a negedge monitor drains.
module tb_gt_sync_rx;

  logic        clk;
  logic        reset;
  logic        mtclk;
  logic [63:0] TimeCnt;
  logic        synced;
  logic        sync_err;
  logic        frame_err;
  logic [15:0] deviation;

  gt_sync_rx_if #(.BEAT_W(16)) bus ();

  gt_sync_rx #(
    .BEAT_W(16), .LAT_COMP(2), .MAX_DEV(4), .REJECT_LIMIT(2), .TIMEOUT_MT(1024)
  ) dut (
    .clk(clk), .reset(reset), .mtclk(mtclk), .rx(bus),
    .TimeCnt(TimeCnt), .synced(synced), .sync_err(sync_err),
    .frame_err(frame_err), .deviation(deviation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] t;
    logic        s;
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  bit pending    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] t, input logic s, input logic [15:0] d, input logic e);
    exp_t x;
    x.t = t; x.s = s; x.d = d; x.e = e;
    sb.push_back(x);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back beats, then the check cycle with the chosen mtclk level.
  task automatic send_frame(input logic [63:0] t, input logic mt_in_check);
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_sof   = (i == 0);
      bus.rx_data  = t[63-16*i -: 16];
      clk1();
    end
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    mtclk        = mt_in_check;
    chk("ready_low_in_check", 64'(bus.rx_ready), 64'd0);
    clk1();
    mtclk = 1'b0;
  endtask

  task automatic beat(input logic sof, input logic [15:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_sof   = sof;
    bus.rx_data  = d;
    clk1();
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
  endtask

  // Scoreboard monitor: the cycle after the DUT's check cycle carries the result.
  always @(negedge clk) begin
    exp_t e;
    if (pending) begin
      pending = 1'b0;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL sb_unexpected observed=check_cycle expected=none");
      end else begin
        e = sb.pop_front();
        chk("sb_time", TimeCnt, e.t);
        chk("sb_synced", 64'(synced), 64'(e.s));
        chk("sb_deviation", 64'(deviation), 64'(e.d));
        chk("sb_sync_err", 64'(sync_err), 64'(e.e));
      end
    end
    if (bus.rx_ready === 1'b0) pending = 1'b1;
  end

  initial begin
    reset = 1'b1; mtclk = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_sof = 1'b0; bus.rx_data = 16'd0;
    repeat (3) clk1();
    chk("rst_time", TimeCnt, 64'd0);
    chk("rst_synced", 64'(synced), 64'd0);
    chk("rst_ready", 64'(bus.rx_ready), 64'd1);
    chk("rst_dev", 64'(deviation), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;

    // Free-running count before the first frame.
    mtclk = 1'b1;
    repeat (5) clk1();
    mtclk = 1'b0;
    chk("free_run_time", TimeCnt, 64'd5);
    chk("free_run_unsynced", 64'(synced), 64'd0);

    // First frame: unsynced, always accepted; 0x102 - 5 = 0xFD.
    push_exp(64'h102, 1'b1, 16'h00FD, 1'b0);
    send_frame(64'h100, 1'b0);

    // Bring count to 0x200, in-bound frame with mtclk in the check cycle.
    mtclk = 1'b1;
    repeat (254) clk1();
    mtclk = 1'b0;
    chk("pre_inbound_time", TimeCnt, 64'h200);
    push_exp(64'h202, 1'b1, 16'h0001, 1'b0);
    send_frame(64'h1FF, 1'b1);

    // Out-of-bound frames: two rejected, the third force-accepted.
    push_exp(64'h202, 1'b1, 16'h0100, 1'b1);
    send_frame(64'h300, 1'b0);
    push_exp(64'h202, 1'b1, 16'h0100, 1'b1);
    send_frame(64'h300, 1'b0);
    push_exp(64'h302, 1'b1, 16'h0100, 1'b0);
    send_frame(64'h300, 1'b0);

    // Timeout: synced survives 1023 macroticks and drops on the 1024th.
    mtclk = 1'b1;
    repeat (1023) clk1();
    chk("timeout_1023_synced", 64'(synced), 64'd1);
    chk("timeout_1023_time", TimeCnt, 64'h701);
    clk1();
    mtclk = 1'b0;
    chk("timeout_1024_synced", 64'(synced), 64'd0);
    chk("timeout_1024_time", TimeCnt, 64'h702);

    // Restarted frame: partial frame dropped, new frame accepted since unsynced.
    beat(1'b1, 16'hAAAA);
    beat(1'b0, 16'hBBBB);
    chk("partial_no_frame_err", 64'(frame_err), 64'd0);
    beat(1'b1, 16'h0000);
    chk("restart_frame_err", 64'(frame_err), 64'd1);
    beat(1'b0, 16'h0000);
    chk("restart_frame_err_clear", 64'(frame_err), 64'd0);
    beat(1'b0, 16'h0000);
    push_exp(64'h42, 1'b1, 16'hF940, 1'b0);
    beat(1'b0, 16'h0040);
    clk1();

    // Stray non-sof beat while idle.
    beat(1'b0, 16'h1234);
    chk("idle_frame_err", 64'(frame_err), 64'd1);
    chk("idle_ready", 64'(bus.rx_ready), 64'd1);
    clk1();
    chk("idle_frame_err_clear", 64'(frame_err), 64'd0);
    chk("idle_time_kept", TimeCnt, 64'h42);

    // Wrap-around: land on all-ones, then target 1 gives dev +2.
    reset = 1'b1;
    repeat (2) clk1();
    reset = 1'b0;
    chk("rst2_time", TimeCnt, 64'd0);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'hFFFF, 1'b0);
    send_frame(64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    push_exp(64'd1, 1'b1, 16'h0002, 1'b0);
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Reset in the middle of a frame discards the partial data.
    beat(1'b1, 16'h0000);
    beat(1'b0, 16'h0000);
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("midrst_time", TimeCnt, 64'd0);
    chk("midrst_synced", 64'(synced), 64'd0);
    beat(1'b0, 16'h0000);
    chk("midrst_tail_frame_err", 64'(frame_err), 64'd1);
    beat(1'b0, 16'h0500);
    push_exp(64'h502, 1'b1, 16'h0502, 1'b0);
    send_frame(64'h500, 1'b0);

    repeat (3) clk1();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
